sub_serial: RTL and testbench
=============================

Name: sub_serial

Overview:
- Bit-serial subtractor; the inverse-direction companion of the team's ripple-carry adders.
- Computes Diff = A - B - Bin one bit per clock, LSB first, using a single internal full-adder cell fed with inverted B bits and an inverted borrow chain.
- Uses a valid/ready handshake on both the operand and result sides.
- Placed wherever area matters more than latency, such as datapath helpers and test fixtures for the adder blocks.

Parameters:
- WIDTH, 4, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous and active-high.
- in_valid  input  1  operands A, B, Bin are valid this cycle.
- in_ready  output  1  block can accept operands; high only in IDLE.
- A  input  WIDTH  minuend, sampled on the accept edge.
- B  input  WIDTH  subtrahend, sampled on the accept edge.
- Bin  input  1  borrow-in, sampled on the accept edge.
- out_valid  output  1  result is valid; held until taken.
- out_ready  input  1  consumer takes the result.
- Diff  output  WIDTH  A - B - Bin modulo 2^WIDTH.
- Bout  output  1  borrow-out; 1 when A < B + Bin as unsigned values.
- Ovf  output  1  two's-complement overflow of the subtraction.
- Zero  output  1  Diff == 0.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - State goes to IDLE and the bit counter clears.
  - Operand and shift registers clear.
  - Diff=0, Bout=0, Ovf=0, Zero=0, out_valid=0, in_ready=1 immediately on rst assertion.
  - Any operation in progress is discarded; nothing is emitted after reset releases.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a rising edge with in_valid=1: latch A, B and Bin; set the internal carry to ~Bin; counter=0; go to RUN.
  - With in_valid=0 the block stays in IDLE.
- RUN:
  - in_ready=0, out_valid=0; in_valid is ignored.
  - Each edge computes bit k = A[k] ^ ~B[k] ^ c.
  - Each edge updates carry c = majority(A[k], ~B[k], c) and shifts the bit into the diff shift register from the MSB side.
  - Counter increments on each edge.
  - On the edge processing bit WIDTH-1, go to DONE.
- RUN completion edge, which loads the result registers:
  - Diff = the full assembled difference.
  - Bout = ~(final carry).
  - Ovf = (A[WIDTH-1] != B[WIDTH-1]) & (Diff[WIDTH-1] != A[WIDTH-1]).
  - Zero = (Diff == 0).
- Latency: exactly WIDTH rising edges from the accept edge to out_valid=1.
  - For WIDTH=4, accept at edge E0 gives out_valid high after E4.
- DONE:
  - out_valid=1, in_ready=0.
  - While out_ready=0, all outputs are held stable indefinitely.
  - On an edge with out_ready=1, go to IDLE; out_valid drops after that edge.
  - Diff, Bout, Ovf and Zero keep their last values until the next completion.
- Result outputs change only on a completion edge or on reset. They never show partial results.
- No back-to-back overlap: a new operand is accepted no earlier than the edge after the result handoff.
  - Maximum throughput is one operation per WIDTH+2 cycles.
- out_ready asserted outside DONE has no effect.
- Operands are registered on acceptance. A, B and Bin may change freely during RUN and DONE.
- All arithmetic is modulo 2^WIDTH. Bout is the unsigned borrow; Ovf is the signed overflow; both are computed as above.

Test Plan:
- Reset and idle: assert rst mid-cycle -> in_ready=1, out_valid=0, Diff=0, Bout=0, Ovf=0, Zero=0 immediately; release rst with in_valid=0 for 10 cycles -> no change.
- Basic, WIDTH=4: A=7, B=3, Bin=0, out_ready=1 -> exactly 4 edges after accept, out_valid=1 for 1 cycle with Diff=4, Bout=0, Ovf=0, Zero=0.
- Borrow and signed overflow:
  - A=3, B=7 -> Diff=12, Bout=1, Ovf=0.
  - A=7, B=8 (i.e. 7 - (-8)) -> Diff=15, Bout=1, Ovf=1.
- Zero and borrow-in:
  - A=5, B=5, Bin=0 -> Diff=0, Zero=1, Bout=0.
  - A=0, B=0, Bin=1 -> Diff=15, Bout=1, Zero=0, Ovf=0.
- Backpressure and operand independence: out_ready=0 for 6 cycles after completion, with A/B toggled and in_valid=1 during RUN/DONE -> out_valid stays 1, in_ready stays 0, outputs are stable; raise out_ready -> IDLE next cycle, and the next accept happens only after that.
- Reset mid-operation: accept A=9, B=2, then assert rst after 2 RUN edges -> IDLE immediately, no out_valid after release; then A=9, B=2 -> Diff=7 after 4 edges.

Source files
------------

// File: rtl/sub_serial_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// master drives operands and takes results; slave is the subtractor itself.
interface sub_serial_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Ovf;
  logic             Zero;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, Diff, Bout, Ovf, Zero
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, Diff, Bout, Ovf, Zero
  );
endinterface

// File: rtl/sub_serial.sv
// Bit-serial A - B - Bin, LSB first, one full-adder cell fed with ~B and an inverted borrow.
// WIDTH edges from accept to out_valid; result held in DONE until out_ready, no overlap.
module sub_serial #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  sub_serial_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] diff_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sum_bit;
  logic             carry_nxt;
  logic             nb;
  logic             last_bit;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Carry here is the complement of the running borrow, so the adder cell computes A + ~B + ~Bin.
  always_comb begin
    nb        = ~b_reg[cnt];
    sum_bit   = a_reg[cnt] ^ nb ^ carry;
    carry_nxt = (a_reg[cnt] & nb) | (a_reg[cnt] & carry) | (nb & carry);
    diff_nxt  = {sum_bit, sreg[WIDTH-1:1]};
    last_bit  = (cnt == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sreg     <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      bus.Diff <= '0;
      bus.Bout <= 1'b0;
      bus.Ovf  <= 1'b0;
      bus.Zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.A;
            b_reg <= bus.B;
            carry <= ~bus.Bin;
            cnt   <= '0;
            sreg  <= '0;
          end
        end
        RUN: begin
          sreg  <= diff_nxt;
          carry <= carry_nxt;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            bus.Diff <= diff_nxt;
            bus.Bout <= ~carry_nxt;
            bus.Ovf  <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &
                        (diff_nxt[WIDTH-1] != a_reg[WIDTH-1]);
            bus.Zero <= (diff_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// Randomized self-checking bench for sub_serial against an arithmetic reference model.
module tb_sub_serial;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Last result the model says is on the outputs.
  logic [W-1:0] held_diff = '0;
  logic         held_bout = 1'b0;
  logic         held_ovf  = 1'b0;
  logic         held_zero = 1'b0;

  sub_serial_if #(.WIDTH(W)) bus ();

  sub_serial #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_held(input string tag);
    check({tag, "_diff"}, 32'(bus.Diff), 32'(held_diff));
    check({tag, "_bout"}, 32'(bus.Bout), 32'(held_bout));
    check({tag, "_ovf"},  32'(bus.Ovf),  32'(held_ovf));
    check({tag, "_zero"}, 32'(bus.Zero), 32'(held_zero));
  endtask

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int ua, ub, sa, sb, sd;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 2 ** (W - 1)) ? ua - 2 ** W : ua;
    sb = (ub >= 2 ** (W - 1)) ? ub - 2 ** W : ub;
    sd = sa - sb - int'(bin);
    held_diff = W'((ua - ub - int'(bin) + 2 ** (W + 1)) % (2 ** W));
    held_bout = (ua < ub + int'(bin));
    held_ovf  = (sd < -(2 ** (W - 1))) || (sd > 2 ** (W - 1) - 1);
    held_zero = (held_diff == '0);
  endtask

  task automatic scramble();
    bus.A        = W'($urandom);
    bus.B        = W'($urandom);
    bus.Bin      = 1'($urandom);
    bus.in_valid = 1'($urandom);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input int hold);
    int lat;
    @(negedge clk);
    bus.A         = a;
    bus.B         = b;
    bus.Bin       = bin;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    check("ready_before_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    lat = 0;
    while (!bus.out_valid && lat < 3 * W) begin
      check("in_ready_run", 32'(bus.in_ready), 32'd0);
      check("diff_stable_run", 32'(bus.Diff), 32'(held_diff));
      scramble();
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(W));
    model(a, b, bin);
    check_held("result");
    check("in_ready_done", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      scramble();
      @(posedge clk);
      #1;
      check("out_valid_hold", 32'(bus.out_valid), 32'd1);
      check("in_ready_hold", 32'(bus.in_ready), 32'd0);
      check("diff_hold", 32'(bus.Diff), 32'(held_diff));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("in_ready_back", 32'(bus.in_ready), 32'd1);
    check_held("after_take");
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Bin       = 1'b0;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_held("rst");
    @(negedge clk);
    rst = 1'b0;

    // Load a nonzero result, then reset asynchronously mid-cycle.
    do_op(4'd3, 4'd7, 1'b0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    held_diff = '0; held_bout = 1'b0; held_ovf = 1'b0; held_zero = 1'b0;
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check_held("arst");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("idle_in_ready", 32'(bus.in_ready), 32'd1);
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);
      check("idle_diff", 32'(bus.Diff), 32'd0);
    end

    // Directed corner cases.
    do_op(4'd7, 4'd3, 1'b0, 0);
    do_op(4'd3, 4'd7, 1'b0, 0);
    do_op(4'd7, 4'd8, 1'b0, 0);
    do_op(4'd5, 4'd5, 1'b0, 0);
    do_op(4'd0, 4'd0, 1'b1, 0);
    do_op(4'd8, 4'd1, 1'b0, 2);
    do_op(4'd6, 4'd2, 1'b1, 6);

    // Reset two RUN edges into an operation.
    @(negedge clk);
    bus.A = 4'd9; bus.B = 4'd2; bus.Bin = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    held_diff = '0; held_bout = 1'b0; held_ovf = 1'b0; held_zero = 1'b0;
    check("midop_in_ready", 32'(bus.in_ready), 32'd1);
    check("midop_out_valid", 32'(bus.out_valid), 32'd0);
    check_held("midop");
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      check("midop_no_emit", 32'(bus.out_valid), 32'd0);
    end
    do_op(4'd9, 4'd2, 1'b0, 0);

    for (int i = 0; i < 40; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
